// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX/MEM training signals shared between the core and branch_predictor.
// master = core side (drives PCs and training), slave = predictor.
interface branch_predictor_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      fetch_pc;
  logic             predict_taken;
  logic [31:0]      predict_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_is_jump;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             mispredict;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
    input  predict_taken, predict_target, mispredict, mispredict_count
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
    output predict_taken, predict_target, mispredict, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// BTB with 2-bit direction counters, same-cycle fetch prediction and a mispredict counter.
// Optional gshare direction table enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 32
) (
  input logic               CLK,
  input logic               nRST,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [CNT_W-1:0] r_count;

  logic [IDX_W-1:0] w_fIdx, w_uIdx, w_fCtrIdx, w_uCtrIdx;
  logic [TAG_W-1:0] w_fTag, w_uTag;
  logic             w_fHit, w_uHit, w_fTaken;
  logic [1:0]       w_uCtr, w_nextCtr;
  logic             w_predTaken, w_actTaken, w_misp;
  logic             w_ctrWe, w_btbWe;

  assign w_fIdx = bus.fetch_pc[IDX_W+1:2];
  assign w_fTag = bus.fetch_pc[31:IDX_W+2];
  assign w_uIdx = bus.upd_pc[IDX_W+1:2];
  assign w_uTag = bus.upd_pc[31:IDX_W+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // Both lookup ports hash with the current history, before this cycle's shift
  assign w_fCtrIdx = w_fIdx ^ r_ghr;
  assign w_uCtrIdx = w_uIdx ^ r_ghr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ghr <= '0;
    end else if (bus.upd_valid && !bus.upd_is_jump) begin
      r_ghr <= IDX_W'({r_ghr, bus.upd_taken});
    end
  end
`else
  assign w_fCtrIdx = w_fIdx;
  assign w_uCtrIdx = w_uIdx;
`endif

  assign w_fHit   = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);
  assign w_fTaken = w_fHit && r_ctr[w_fCtrIdx][1];

  assign bus.predict_taken  = w_fTaken;
  assign bus.predict_target = w_fTaken ? r_target[w_fIdx] : bus.fetch_pc + 32'd4;

  // Second lookup on upd_pc sees pre-update state, so mispredict reflects what fetch saw
  assign w_uHit      = r_valid[w_uIdx] && (r_tag[w_uIdx] == w_uTag);
  assign w_uCtr      = r_ctr[w_uCtrIdx];
  assign w_predTaken = w_uHit && w_uCtr[1];
  assign w_actTaken  = bus.upd_is_jump || bus.upd_taken;
  assign w_misp      = bus.upd_valid &&
                       ((w_predTaken != w_actTaken) ||
                        (w_predTaken && w_actTaken && (r_target[w_uIdx] != bus.upd_target)));

  assign bus.mispredict       = w_misp;
  assign bus.mispredict_count = r_count;

  always_comb begin
    w_nextCtr = w_uCtr;
    if (bus.upd_is_jump) begin
      w_nextCtr = 2'b11;
    end else if (!w_uHit) begin
      w_nextCtr = 2'b10;
    end else if (bus.upd_taken) begin
      w_nextCtr = (w_uCtr == 2'b11) ? 2'b11 : w_uCtr + 2'b01;
    end else begin
      w_nextCtr = (w_uCtr == 2'b00) ? 2'b00 : w_uCtr - 2'b01;
    end
  end

  // A miss that was not taken leaves every table untouched
  assign w_ctrWe = bus.upd_valid && (w_uHit || w_actTaken);
  assign w_btbWe = bus.upd_valid && w_actTaken;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_INIT;
      end
      r_count <= '0;
    end else begin
      if (w_btbWe) begin
        r_valid[w_uIdx] <= 1'b1;
      end
      if (w_ctrWe) begin
        r_ctr[w_uCtrIdx] <= w_nextCtr;
      end
      if (w_misp) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Tags and targets need no reset; valid bits hide stale contents
  always_ff @(posedge CLK) begin
    if (w_btbWe && nRST) begin
      r_tag[w_uIdx]    <= w_uTag;
      r_target[w_uIdx] <= bus.upd_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus pushes expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_branch_predictor;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       name;
    logic        expTaken;
    logic [31:0] expTarget;
    bit          useMisp;
    logic        expMisp;
    logic [31:0] expCount;
  } expT;

  expT sbQ[$];

  branch_predictor_if #(.CNT_W(32)) bus ();

  branch_predictor #(
    .ENTRIES (16),
    .CTR_INIT(2'b01),
    .CNT_W   (32)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge
  initial begin
    expT e;
    forever begin
      @(negedge CLK);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput({e.name, ".taken"},  32'(bus.predict_taken),  32'(e.expTaken));
        checkOutput({e.name, ".target"}, bus.predict_target,      e.expTarget);
        checkOutput({e.name, ".count"},  bus.mispredict_count,    e.expCount);
        if (e.useMisp) begin
          checkOutput({e.name, ".misp"}, 32'(bus.mispredict),     32'(e.expMisp));
        end
      end
    end
  end

  task automatic applyStimulus(
    input string       name,
    input bit          rstLow,
    input logic [31:0] fpc,
    input bit          uv,
    input logic [31:0] upc,
    input bit          uj,
    input bit          ut,
    input logic [31:0] utgt,
    input bit          eTaken,
    input logic [31:0] eTarget,
    input bit          useMisp,
    input bit          eMisp,
    input logic [31:0] eCount
  );
    expT e;
    @(posedge CLK);
    #1;
    nRST            = !rstLow;
    bus.fetch_pc    = fpc;
    bus.upd_valid   = uv;
    bus.upd_pc      = upc;
    bus.upd_is_jump = uj;
    bus.upd_taken   = ut;
    bus.upd_target  = utgt;
    e.name      = name;
    e.expTaken  = eTaken;
    e.expTarget = eTarget;
    e.useMisp   = useMisp;
    e.expMisp   = eMisp;
    e.expCount  = eCount;
    sbQ.push_back(e);
  endtask

  task automatic idle(input string name, input logic [31:0] fpc, input bit eTaken,
                      input logic [31:0] eTarget, input logic [31:0] eCount);
    applyStimulus(name, 0, fpc, 0, 32'h0, 0, 0, 32'h0, eTaken, eTarget, 1, 0, eCount);
  endtask

  task automatic update(input string name, input logic [31:0] fpc, input logic [31:0] upc,
                        input bit uj, input bit ut, input logic [31:0] utgt,
                        input bit eTaken, input logic [31:0] eTarget,
                        input bit eMisp, input logic [31:0] eCount);
    applyStimulus(name, 0, fpc, 1, upc, uj, ut, utgt, eTaken, eTarget, 1, eMisp, eCount);
  endtask

  initial begin
    int drain;
    bus.fetch_pc    = 32'h0;
    bus.upd_valid   = 1'b0;
    bus.upd_pc      = 32'h0;
    bus.upd_is_jump = 1'b0;
    bus.upd_taken   = 1'b0;
    bus.upd_target  = 32'h0;

    applyStimulus("reset", 1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h104, 1, 0, 0);
    idle("reset_rel", 32'h100, 0, 32'h104, 0);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    // Alternating T/N on 0x20: mispredicts on updates 1, 3, 5, then fully trained
    for (int i = 0; i < 8; i++) begin
      applyStimulus("gs_train", 0, 32'h100, 1, 32'h20, 0, (i % 2) == 0, 32'h100,
                    0, 32'h104, 0, 0, 32'(i == 0 ? 0 : (i <= 2 ? 1 : (i <= 4 ? 2 : 3))));
    end
    for (int i = 0; i < 8; i++) begin
      update("gs_trained", 32'h100, 32'h20, 0, (i % 2) == 0, 32'h100, 0, 32'h104, 0, 3);
    end
    idle("gs_final", 32'h100, 0, 32'h104, 3);
    applyStimulus("gs_rst_mid", 1, 32'h20, 1, 32'h20, 0, 1, 32'h100, 0, 32'h24, 0, 0, 0);
    idle("gs_after_rst", 32'h20, 0, 32'h24, 0);
`else
    update("alloc_0x40", 32'h40, 32'h40, 0, 1, 32'h80, 0, 32'h44, 1, 0);
    idle("pred_0x40", 32'h40, 1, 32'h80, 1);

    update("sat_t1", 32'h40, 32'h40, 0, 1, 32'h80, 1, 32'h80, 0, 1);
    update("sat_t2", 32'h40, 32'h40, 0, 1, 32'h80, 1, 32'h80, 0, 1);
    update("sat_t3", 32'h40, 32'h40, 0, 1, 32'h80, 1, 32'h80, 0, 1);
    update("sat_n1", 32'h40, 32'h40, 0, 0, 32'h80, 1, 32'h80, 1, 1);
    update("sat_n2", 32'h40, 32'h40, 0, 0, 32'h80, 1, 32'h80, 1, 2);
    idle("sat_after", 32'h40, 0, 32'h44, 3);

    // ctr is 01: taken update mispredicts, ctr->10
    update("realloc_0x40", 32'h40, 32'h40, 0, 1, 32'h80, 0, 32'h44, 1, 3);
    update("jal_alias", 32'h40, 32'h80, 1, 0, 32'h200, 1, 32'h80, 1, 4);
    idle("alias_miss", 32'h40, 0, 32'h44, 5);
    idle("alias_jal", 32'h80, 1, 32'h200, 5);
    update("jal_newtgt", 32'h80, 32'h80, 1, 0, 32'h300, 1, 32'h200, 1, 5);
    idle("jal_tgt_upd", 32'h80, 1, 32'h300, 6);

    update("same_cycle", 32'h10, 32'h10, 0, 1, 32'h400, 0, 32'h14, 1, 6);
    idle("same_next", 32'h10, 1, 32'h400, 7);

    update("miss_nt", 32'h14, 32'h14, 0, 0, 32'h700, 0, 32'h18, 0, 7);
    idle("miss_nt_next", 32'h14, 0, 32'h18, 7);

    applyStimulus("upd_invalid", 0, 32'h18, 0, 32'h18, 1, 1, 32'h999, 0, 32'h1c, 1, 0, 7);
    idle("invalid_next", 32'h18, 0, 32'h1c, 7);

    applyStimulus("rst_mid", 1, 32'h10, 1, 32'h24, 0, 1, 32'h500, 0, 32'h14, 0, 0, 0);
    idle("rst_no_alloc", 32'h24, 0, 32'h28, 0);
    idle("rst_0x40", 32'h40, 0, 32'h44, 0);
    idle("rst_0x80", 32'h80, 0, 32'h84, 0);
    idle("rst_0x10", 32'h10, 0, 32'h14, 0);
`endif

    drain = 0;
    while (sbQ.size() > 0 && drain < 10) begin
      @(negedge CLK);
      drain++;
    end
    #1;
    if (sbQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d expected=0 pending expectations", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined RISC-V core.
- Supplies the fetch stage with a same-cycle taken/target prediction for the current PC.
- Is trained from the EX/MEM latch when a resolved branch or JAL retires there.
- Replaces the fixed "predict not-taken, redirect from EX/MEM" policy and keeps a mispredict statistics counter.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2. IDX_W = log2(ENTRIES).
- CTR_INIT, 2'b01, direction counter value after reset (weakly not-taken).
- CNT_W, 32, width of the mispredict counter.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- fetch_pc  input  32  PC currently presented to imem.
- predict_taken  output  1  predict redirect for fetch_pc.
- predict_target  output  32  next PC to fetch: BTB target if predict_taken, else fetch_pc+4.
- upd_valid  input  1  one resolved control-flow instruction to train on; single-cycle pulse, qualified with the pipeline enable by the caller.
- upd_pc  input  32  PC of the resolved instruction.
- upd_is_jump  input  1  instruction is an unconditional JAL.
- upd_taken  input  1  actual outcome; ignored, and treated as 1, when upd_is_jump=1.
- upd_target  input  32  actual taken target.
- mispredict  output  1  combinational; upd_valid and the table's prediction for upd_pc (direction or target) differs from the actual outcome.
- mispredict_count  output  CNT_W  registered count of mispredict pulses.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] is ignored.
- Entry storage: valid, tag, target[31:0], ctr[1:0]. Storage is flops; there is no memory macro.
- Lookup (combinational, 0 latency):
  - hit = valid[idx] && tag match.
  - predict_taken = hit && ctr[1].
  - predict_target = predict_taken ? target : fetch_pc+4, modulo 2^32.
- Update, registered on posedge CLK when upd_valid=1:
  - Hit, jump: ctr<=2'b11; target<=upd_target.
  - Hit, conditional taken: ctr saturating +1 (2'b11 holds); target<=upd_target.
  - Hit, conditional not-taken: ctr saturating -1 (2'b00 holds); target unchanged.
  - Miss and taken (or jump): allocate; valid<=1, tag, target<=upd_target. ctr<=2'b11 for a jump, 2'b10 for a branch. This overwrites any conflicting entry.
  - Miss and not-taken: no allocation, no state change.
- Mispredict determination:
  - Uses a second, independent lookup port on upd_pc, evaluated against pre-update state.
  - mispredict = (pred_taken != actual_taken) || (pred_taken && actual_taken && pred_target != upd_target).
- mispredict_count increments by 1 on each cycle with mispredict=1 and wraps modulo 2^CNT_W.
- Simultaneous lookup and update of the same index: lookup returns the pre-update state. There is no write-through bypass; the new state is visible on the next cycle.
- Reset (asynchronous, nRST low):
  - All valid<=0, ctr<=CTR_INIT, mispredict_count<=0; targets and tags are don't-care.
  - Outputs therefore read predict_taken=0, predict_target=fetch_pc+4, mispredict=0 while no update is valid.
  - Reset mid-update discards the pending write.
- Upd inputs with upd_valid=0 never alter state.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- When defined:
  - Direction counters move to a separate ENTRIES-deep pattern table indexed by index XOR ghr.
  - ghr is an IDX_W-bit global history register, reset to 0.
  - The BTB keeps valid, tag and target only.
  - Lookup hit still requires a BTB tag match.
  - On every upd_valid conditional branch, after the counter update, ghr <= {ghr[IDX_W-2:0], upd_taken}. Jumps do not shift ghr.
  - Counter lookups for both prediction and mispredict use the current ghr value.
  - A jump miss allocates its BTB entry; its ctr write goes to the pattern table (2'b11).
- When undefined: per-entry counters as in Behaviour; no ghr exists.

Test Plan (ENTRIES=16, CTR_INIT=01 unless stated):
- Reset, fetch_pc=0x100 -> predict_taken=0, predict_target=0x104, mispredict_count=0.
- Update: pc=0x40, conditional, taken, target=0x80 -> same cycle mispredict=1; next cycle fetch_pc=0x40 gives predict_taken=1, target=0x80; count=1.
- Counter saturation: pc=0x40 taken x3 then not-taken x2 -> count stays 1 after the taken updates, then increments to 2 on the first not-taken (ctr 11->10 still predicts taken). The second not-taken (ctr 10->01) is also a mispredict, so count=3, and after it predict_taken=0.
- Aliasing: allocate 0x40->0x80, then JAL pc=0x80 (same index, different tag) target=0x200 -> fetch_pc=0x40 misses (predict_target=0x44); fetch_pc=0x80 predicts 0x200 with ctr=11.
- Same-cycle read/write: fetch_pc=upd_pc=0x10, taken, first allocation -> predict_taken=0 that cycle, 1 the next cycle.
- Reset asserted mid-sequence with upd_valid=1 -> all entries invalid, count=0, no allocation survives; with GSHARE_EN, ghr=0 and alternating T/N on pc=0x20 reaches zero mispredicts after training.
